sun2_timer_ctl_p: RTL and testbench

Parametrised timer controller for the CPU board, running at the 100-ns system clock.
- Divides the 200-ns tick enable through a prescaler.
- Issues DRAM refresh requests and counts overruns when a request is still pending.
- Generates the bus-cycle timeout and its half-way warning.
- Drives a qualified watchdog reset pulse.
- Replaces the fixed 6-stage ripple-style timer PAL with configurable depths and a finite reset pulse.

---
 rtl/sun2_timer_pkg.sv | 26 ++
 rtl/sun2_timer_prescale.sv | 26 ++
 rtl/sun2_timer_ctl_p.sv | 118 +++++++++++
 tb/tb_sun2_timer_ctl_p.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sun2_timer_pkg.sv
// Shared constants and helpers for the CPU-board timer controller.
// Defaults match the production board; the AS counter width is derived from the timeout depth.
package sun2_timer_pkg;

  localparam int DEF_PRE_W         = 8;
  localparam int DEF_TIMEOUT_TICKS = 128;
  localparam int DEF_WDOG_PERIODS  = 4;
  localparam int DEF_INIT_CYCLES   = 16;
  localparam int DEF_OVR_W         = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // One extra bit so the counter can hold TIMEOUT_TICKS itself and saturate there.
  localparam int DEF_AS_W = clog2(DEF_TIMEOUT_TICKS) + 1;

endpackage

// File: rtl/sun2_timer_prescale.sv
// Tick-enabled free-running divider; carry is combinational in the cycle the count wraps.
// Count updates 1 clk after tick; no backpressure.
module sun2_timer_prescale #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         carry
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;
  assign carry = tick & (&count_q);

endmodule

// File: rtl/sun2_timer_ctl_p.sv
// CPU-board timer: refresh requests with overrun count, bus timeout, watchdog-driven init pulse.
// All outputs registered, 1 clk after the causing input; no backpressure (ren only retires rreq).
module sun2_timer_ctl_p
  import sun2_timer_pkg::*;
#(
  parameter int PRE_W         = DEF_PRE_W,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int WDOG_PERIODS  = DEF_WDOG_PERIODS,
  parameter int INIT_CYCLES   = DEF_INIT_CYCLES,
  parameter int OVR_W         = DEF_OVR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ren,
  input  logic             as,
  input  logic             tin,
  input  logic             halt,
  input  logic             sds,
  input  logic             sysb,
  input  logic             wdog_en,
  output logic [PRE_W-1:0] prescale,
  output logic             rreq,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic             t_half,
  output logic             timeout,
  output logic             init
);

  localparam int AS_W   = clog2(TIMEOUT_TICKS) + 1;
  localparam int WD_W   = clog2(WDOG_PERIODS) + 1;
  localparam int INIT_W = clog2(INIT_CYCLES) + 1;

  logic              carry;
  logic              qual;
  logic              fire;
  logic              rreq_q, rreq_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic [AS_W-1:0]   as_cnt_q, as_cnt_d;
  logic              half_q, half_d;
  logic              to_q, to_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_q, init_d;

  sun2_timer_prescale #(.W(PRE_W)) u_prescale (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .count (prescale),
    .carry (carry)
  );

  always_comb begin
    qual = wdog_en & halt & ~sds & ~sysb;
    // The watchdog is blind while init is already asserted, so it cannot re-fire mid-pulse.
    fire = ~init_q & qual & carry & (wd_q == WD_W'(WDOG_PERIODS - 1));

    rreq_d = (rreq_q | carry) & ~ren;
    ovr_d  = ovr_q;
    if (carry & rreq_q & ~ren & ~(&ovr_q)) ovr_d = ovr_q + OVR_W'(1);

    as_cnt_d = as_cnt_q;
    if (!as) begin
      as_cnt_d = '0;
    end else if (tick && (as_cnt_q != AS_W'(TIMEOUT_TICKS))) begin
      as_cnt_d = as_cnt_q + AS_W'(1);
    end
    half_d = as & (half_q | (as_cnt_q == AS_W'(TIMEOUT_TICKS / 2)));
    to_d   = as & (to_q | tin | (as_cnt_q == AS_W'(TIMEOUT_TICKS)));

    wd_d = wd_q;
    if (init_q | ~qual | fire) begin
      wd_d = '0;
    end else if (carry) begin
      wd_d = wd_q + WD_W'(1);
    end

    init_cnt_d = init_cnt_q;
    init_d     = init_q;
    if (fire) begin
      init_cnt_d = INIT_W'(INIT_CYCLES);
      init_d     = 1'b1;
    end else if (init_cnt_q != '0) begin
      init_cnt_d = init_cnt_q - INIT_W'(1);
      init_d     = (init_cnt_q != INIT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rreq_q     <= 1'b0;
      ovr_q      <= '0;
      as_cnt_q   <= '0;
      half_q     <= 1'b0;
      to_q       <= 1'b0;
      wd_q       <= '0;
      init_cnt_q <= INIT_W'(INIT_CYCLES);
      init_q     <= 1'b1;
    end else begin
      rreq_q     <= rreq_d;
      ovr_q      <= ovr_d;
      as_cnt_q   <= as_cnt_d;
      half_q     <= half_d;
      to_q       <= to_d;
      wd_q       <= wd_d;
      init_cnt_q <= init_cnt_d;
      init_q     <= init_d;
    end
  end

  assign rreq    = rreq_q;
  assign ovr_cnt = ovr_q;
  assign t_half  = half_q;
  assign timeout = to_q;
  assign init    = init_q;

endmodule

// File: tb/tb_sun2_timer_ctl_p.sv
// Directed plus randomized bench for sun2_timer_ctl_p against an integer reference model.
module tb_sun2_timer_ctl_p;

  localparam int PRE_W = 4;
  localparam int TT    = 8;
  localparam int WP    = 2;
  localparam int IC    = 3;
  localparam int OVR_W = 2;
  localparam int PMAX  = (1 << PRE_W) - 1;
  localparam int OMAX  = (1 << OVR_W) - 1;

  logic             clk = 1'b0;
  logic             reset, tick, ren, as, tin, halt, sds, sysb, wdog_en;
  logic [PRE_W-1:0] prescale;
  logic             rreq;
  logic [OVR_W-1:0] ovr_cnt;
  logic             t_half, timeout, init;

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers describing the observable timer behaviour.
  int m_pre, m_rreq, m_ovr, m_asc, m_half, m_to, m_wd, m_init_left, m_init;

  sun2_timer_ctl_p #(
    .PRE_W(PRE_W), .TIMEOUT_TICKS(TT), .WDOG_PERIODS(WP),
    .INIT_CYCLES(IC), .OVR_W(OVR_W)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ren(ren), .as(as), .tin(tin),
    .halt(halt), .sds(sds), .sysb(sysb), .wdog_en(wdog_en),
    .prescale(prescale), .rreq(rreq), .ovr_cnt(ovr_cnt),
    .t_half(t_half), .timeout(timeout), .init(init)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int carry, qual, fire;
    if (reset) begin
      m_pre = 0; m_rreq = 0; m_ovr = 0; m_asc = 0; m_half = 0; m_to = 0;
      m_wd = 0; m_init_left = IC; m_init = 1;
    end else begin
      carry = (tick && m_pre == PMAX) ? 1 : 0;
      if (tick) m_pre = (m_pre + 1) % (PMAX + 1);
      if (carry && m_rreq && !ren && m_ovr < OMAX) m_ovr = m_ovr + 1;
      m_rreq = ((m_rreq || carry) && !ren) ? 1 : 0;
      m_half = (as && (m_half || m_asc == TT / 2)) ? 1 : 0;
      m_to   = (as && (m_to || tin || m_asc == TT)) ? 1 : 0;
      if (!as) m_asc = 0;
      else if (tick && m_asc < TT) m_asc = m_asc + 1;
      qual = (wdog_en && halt && !sds && !sysb) ? 1 : 0;
      fire = (!m_init && qual && carry && m_wd + 1 == WP) ? 1 : 0;
      if (m_init || !qual || fire) m_wd = 0;
      else if (carry) m_wd = m_wd + 1;
      if (fire) begin
        m_init_left = IC; m_init = 1;
      end else if (m_init_left > 0) begin
        m_init_left = m_init_left - 1;
        m_init = (m_init_left > 0) ? 1 : 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("prescale", 32'(prescale), m_pre);
    chk("rreq",     32'(rreq),     m_rreq);
    chk("ovr_cnt",  32'(ovr_cnt),  m_ovr);
    chk("t_half",   32'(t_half),   m_half);
    chk("timeout",  32'(timeout),  m_to);
    chk("init",     32'(init),     m_init);
  endtask

  initial begin
    int hi;
    reset = 1; tick = 0; ren = 0; as = 0; tin = 0;
    halt = 0; sds = 0; sysb = 0; wdog_en = 0;
    m_pre = 0; m_rreq = 0; m_ovr = 0; m_asc = 0; m_half = 0; m_to = 0;
    m_wd = 0; m_init_left = IC; m_init = 1;

    repeat (5) cyc();
    reset = 0;
    // init spans the release cycle plus IC-1 further sampled cycles.
    hi = 0;
    repeat (6) begin cyc(); if (init) hi++; end
    chk("init_len_after_reset", hi, IC - 1);

    for (int i = 0; i < 160; i++) begin
      tick = (i % 2 == 0);
      cyc();
    end
    chk("ovr_saturated", 32'(ovr_cnt), 3);
    chk("rreq_pending", 32'(rreq), 1);

    while (m_pre != PMAX) begin tick = 1; cyc(); end
    tick = 1; ren = 1;
    cyc();
    chk("ren_beats_carry", 32'(rreq), 0);
    chk("ovr_hold_on_ren", 32'(ovr_cnt), 3);
    tick = 0; ren = 0;
    cyc();

    as = 1; tick = 1;
    repeat (5) cyc();
    chk("t_half_after_4_ticks", 32'(t_half), 1);
    chk("no_timeout_yet", 32'(timeout), 0);
    repeat (5) cyc();
    chk("timeout_after_8_ticks", 32'(timeout), 1);
    as = 0;
    cyc();
    chk("timeout_drop", 32'(timeout), 0);
    chk("t_half_drop", 32'(t_half), 0);

    as = 1; tick = 1;
    cyc(); cyc();
    tin = 1;
    cyc();
    chk("tin_timeout", 32'(timeout), 1);
    chk("tin_no_half", 32'(t_half), 0);
    tin = 0; as = 0; tick = 0;
    cyc();
    as = 1; tin = 1;
    cyc();
    as = 0;
    cyc();
    chk("tin_needs_as", 32'(timeout), 0);
    tin = 0;

    wdog_en = 1; halt = 1; tick = 1;
    hi = 0;
    repeat (40) begin cyc(); if (init) hi++; end
    chk("wdog_pulse_len", hi, IC);
    repeat (20) cyc();
    sds = 1;
    cyc();
    sds = 0;
    repeat (40) cyc();

    wdog_en = 0; as = 1;
    repeat (10) cyc();
    reset = 1;
    cyc();
    chk("reset_kills_timeout", 32'(timeout), 0);
    chk("reset_prescale", 32'(prescale), 0);
    reset = 0; as = 0;
    cyc(); cyc();
    reset = 1;
    cyc();
    reset = 0;
    hi = 0;
    repeat (6) begin cyc(); if (init) hi++; end
    chk("init_restart_len", hi, IC - 1);

    for (int i = 0; i < 3000; i++) begin
      tick    = 1'($urandom_range(0, 1));
      ren     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) as = ~as;
      tin     = ($urandom_range(0, 15) == 0);
      halt    = ($urandom_range(0, 9) != 0);
      sds     = ($urandom_range(0, 19) == 0);
      sysb    = ($urandom_range(0, 29) == 0);
      wdog_en = ($urandom_range(0, 9) != 0);
      reset   = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
